// File: rtl/aes_stream_host_if.sv
`timescale 1ns/1ps
// Signal bundle tying aes_stream_host to the word-stream fabric, the key writer and the AES core.
// master: the host controller view; slave: the surrounding fabric/core view.
interface aes_stream_host_if;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IDX_W   = 2;

  logic [WORD_W-1:0]  key_data;
  logic [IDX_W-1:0]   key_idx;
  logic               key_we;
  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               aes_ld;
  logic [BLOCK_W-1:0] aes_key;
  logic [BLOCK_W-1:0] aes_text_in;
  logic               aes_done;
  logic [BLOCK_W-1:0] aes_text_out;
  logic               busy;
  logic               err;
  logic               err_clr;

  modport master (
    input  key_data, key_idx, key_we, in_data, in_valid, out_ready,
           aes_done, aes_text_out, err_clr,
    output in_ready, out_data, out_valid, aes_ld, aes_key, aes_text_in, busy, err
  );

  modport slave (
    output key_data, key_idx, key_we, in_data, in_valid, out_ready,
           aes_done, aes_text_out, err_clr,
    input  in_ready, out_data, out_valid, aes_ld, aes_key, aes_text_in, busy, err
  );
endinterface

// File: rtl/aes_stream_host.sv
`timescale 1ns/1ps
// Host-side AES controller: packs four input words into a block, pulses the core's load, streams four result words back.
// Define AES_STREAM_TIMEOUT_EN to abandon a block after TIMEOUT WAIT cycles and raise the sticky err flag.
module aes_stream_host #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  aes_stream_host_if.master bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 4;
  localparam int unsigned WCNT_W = 2;
  localparam int unsigned TCNT_W = 8;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_FILL  = 2'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd3;

  typedef logic [NWORDS-1:0][WORD_W-1:0] block_t;

  logic [ST_W-1:0]   state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  block_t            text_q, text_d;
  block_t            key_q, key_d;
  block_t            obuf_q, obuf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              ld_q, ld_d;
  logic              busy_q, busy_d;
  logic              tmo_hit_c;
  logic [WCNT_W-1:0] slot_c;
  logic [WCNT_W-1:0] kslot_c;

  // Word 0 of a block / key index 0 lands in the most significant slot.
  assign slot_c  = WCNT_W'(NWORDS - 1) - wcnt_q;
  assign kslot_c = WCNT_W'(NWORDS - 1) - bus.key_idx;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    text_d  = text_q;
    key_d   = key_q;
    obuf_d  = obuf_q;

    // Key must not move while the core is expanding it.
    if (bus.key_we && (state_q == ST_FILL || state_q == ST_DRAIN)) begin
      key_d[kslot_c] = bus.key_data;
    end

    case (state_q)
      ST_FILL: begin
        if (bus.in_valid && in_ready_q) begin
          text_d[slot_c] = bus.in_data;
          wcnt_d         = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(NWORDS - 1)) begin
            wcnt_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.aes_done) begin
          obuf_d  = bus.aes_text_out;
          state_d = ST_DRAIN;
        end else if (tmo_hit_c) begin
          wcnt_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          obuf_d = {obuf_q[NWORDS-2:0], WORD_W'(0)};
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(NWORDS - 1)) begin
            wcnt_d  = '0;
            state_d = ST_FILL;
          end
        end
      end
      default: begin
        wcnt_d  = '0;
        state_d = ST_FILL;
      end
    endcase

    // Status outputs are registered off the next state so they align with it.
    in_ready_d  = (state_d == ST_FILL);
    out_valid_d = (state_d == ST_DRAIN);
    ld_d        = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      wcnt_q      <= '0;
      text_q      <= '0;
      key_q       <= '0;
      obuf_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ld_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      text_q      <= text_d;
      key_q       <= key_d;
      obuf_q      <= obuf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ld_q        <= ld_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AES_STREAM_TIMEOUT_EN
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              err_q, err_d;

  // Counter is zero on WAIT entry; a done in the expiry cycle wins over the timeout.
  always_comb begin
    tcnt_d    = (state_q == ST_WAIT) ? tcnt_q + TCNT_W'(1) : '0;
    tmo_hit_c = (state_q == ST_WAIT) && (tcnt_q + TCNT_W'(1) == TCNT_W'(TIMEOUT));
    err_d     = err_q;
    if (bus.err_clr) begin
      err_d = 1'b0;
    end
    if (tmo_hit_c && !bus.aes_done) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_cfg;

  assign tmo_hit_c  = 1'b0;
  assign bus.err    = 1'b0;
  assign unused_cfg = ^{bus.err_clr, TCNT_W'(TIMEOUT)};
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = obuf_q[NWORDS-1];
  assign bus.aes_ld      = ld_q;
  assign bus.aes_key     = key_q;
  assign bus.aes_text_in = text_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_aes_stream_host.sv
`timescale 1ns/1ps
// Self-checking bench for aes_stream_host: behavioural AES-core stand-in plus a block-level scoreboard.
// The timeout scenario is exercised when AES_STREAM_TIMEOUT_EN is defined.
module tb_aes_stream_host;
  localparam int unsigned TMO    = 8;
  localparam int unsigned BUDGET = 300;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst;
  aes_stream_host_if bus();
  aes_stream_host #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] key_model [4];
  int          core_lat  = 4;
  bit          core_hold = 1'b0;
  logic        core_done  = 1'b0;
  logic        stray_done = 1'b0;
  logic [127:0] core_text = '0;
  int          ld_pulses = 0;

  assign bus.aes_done     = core_done | stray_done;
  assign bus.aes_text_out = core_text;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  // Stand-in cipher: exact FIPS-197 answer for the reference pair, an invertible mix otherwise.
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return {t[95:0], t[127:96]} ^ {k[63:0], k[127:64]} ^ 128'h5a5ac3c30f0f9696a5a53c3cf0f06969;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
    return blk[127 - 32*i -: 32];
  endfunction

  function automatic logic [127:0] model_key();
    return {key_model[0], key_model[1], key_model[2], key_model[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: latches key/text on aes_ld, answers core_lat cycles later unless held or reset.
  initial begin : core_model
    logic [127:0] k;
    logic [127:0] t;
    forever begin
      tick();
      if (bus.aes_ld === 1'b1 && !core_hold) begin
        int i;
        k = bus.aes_key;
        t = bus.aes_text_in;
        i = 0;
        while (i < core_lat && rst === 1'b1) begin
          tick();
          i++;
        end
        if (rst === 1'b1 && !core_hold) begin
          core_done = 1'b1;
          core_text = fake_aes(k, t);
          tick();
          core_done = 1'b0;
          core_text = '0;
        end
      end
    end
  end

  always @(negedge clk) if (bus.aes_ld === 1'b1) ld_pulses++;

  task automatic key_write(input logic [1:0] idx, input logic [31:0] val);
    bus.key_we = 1'b1; bus.key_idx = idx; bus.key_data = val;
    tick();
    bus.key_we = 1'b0; bus.key_data = $urandom();
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = w;
    while (bus.in_ready !== 1'b1 && n < BUDGET) begin tick(); n++; end
    if (n >= BUDGET) begin
      n_checks++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    tick();
    bus.in_valid = 1'b0; bus.in_data = $urandom();
  endtask

  task automatic send_block(input logic [127:0] blk, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      send_word(word_of(blk, i));
    end
  endtask

  task automatic recv_word(input logic [31:0] exp, input int idx, input int max_stall);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < BUDGET) begin tick(); n++; end
    repeat ($urandom_range(0, max_stall)) tick();
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
      $display("FAIL out_word%0d: out_valid=%b out_data=%h, required 1/%h", idx, bus.out_valid, bus.out_data, exp);
    else n_pass++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic recv_block(input logic [127:0] exp, input int max_stall);
    for (int i = 0; i < 4; i++) recv_word(word_of(exp, i), i, max_stall);
  endtask

  task automatic load_fips_key();
    for (int i = 0; i < 4; i++) begin
      key_write(2'(i), word_of(FIPS_KEY, i));
      key_model[i] = word_of(FIPS_KEY, i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.aes_ld !== 1'b0) $display("FAIL rst_aes_ld: got %b, required 0", bus.aes_ld); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b, required 0", bus.err); else n_pass++;
    n_checks++; if (bus.out_data !== 32'd0) $display("FAIL rst_out_data: got %h, required 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.aes_key !== 128'd0) $display("FAIL rst_aes_key: got %h, required 0", bus.aes_key); else n_pass++;
    n_checks++; if (bus.aes_text_in !== 128'd0) $display("FAIL rst_text_in: got %h, required 0", bus.aes_text_in); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_release_pre_edge: in_ready=%b, required 0", bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_edge: in_ready=%b, required 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) key_model[i] = '0;
  endtask

  task automatic test_fips();
    int ld0;
    load_fips_key();
    n_checks++; if (bus.aes_key !== model_key()) $display("FAIL fips_key: aes_key=%h, required %h", bus.aes_key, model_key()); else n_pass++;
    core_lat = 3;
    ld0 = ld_pulses;
    send_block(FIPS_PT, 0);
    n_checks++; if (bus.aes_ld !== 1'b1) $display("FAIL fips_ld_after_4th: aes_ld=%b, required 1", bus.aes_ld); else n_pass++;
    n_checks++; if (bus.aes_text_in !== FIPS_PT) $display("FAIL fips_text_in: got %h, required %h", bus.aes_text_in, FIPS_PT); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL fips_load_status: busy=%b in_ready=%b, required 1/0", bus.busy, bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.aes_ld !== 1'b0 || bus.busy !== 1'b1) $display("FAIL fips_wait_status: aes_ld=%b busy=%b, required 0/1", bus.aes_ld, bus.busy); else n_pass++;
    recv_block(FIPS_CT, 0);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL fips_in_ready_return: got %b, required 1", bus.in_ready); else n_pass++;
    n_checks++; if (ld_pulses - ld0 != 1) $display("FAIL fips_ld_count: got %0d pulses, required 1", ld_pulses - ld0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    core_lat = 5;
    send_block(FIPS_PT, 1);
    while (bus.out_valid !== 1'b1 && n < BUDGET) begin tick(); n++; end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== word_of(FIPS_CT, 0))
        $display("FAIL bp_hold_c%0d: out_valid=%b out_data=%h, required 1/%h", c, bus.out_valid, bus.out_data, word_of(FIPS_CT, 0));
      else n_pass++;
      tick();
    end
    recv_block(FIPS_CT, 2);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL bp_no_extra: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready); else n_pass++;
  endtask

  task automatic test_key_wait();
    logic [127:0] pt;
    core_lat = 8;
    send_block(FIPS_PT, 0);
    tick();
    key_write(2'd0, 32'hffffffff);
    n_checks++; if (bus.aes_key !== FIPS_KEY) $display("FAIL key_wait_dropped: aes_key=%h, required %h", bus.aes_key, FIPS_KEY); else n_pass++;
    recv_block(FIPS_CT, 1);
    key_write(2'd0, 32'hffffffff);
    key_model[0] = 32'hffffffff;
    n_checks++; if (bus.aes_key !== model_key()) $display("FAIL key_fill_taken: aes_key=%h, required %h", bus.aes_key, model_key()); else n_pass++;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_lat = 2;
    send_block(pt, 1);
    recv_block(fake_aes(model_key(), pt), 1);
    key_write(2'd0, word_of(FIPS_KEY, 0));
    key_model[0] = word_of(FIPS_KEY, 0);
  endtask

  task automatic test_stray_done();
    logic [127:0] pt;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_lat = 3;
    send_word(word_of(pt, 0));
    send_word(word_of(pt, 1));
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL stray_done_state: out_valid=%b in_ready=%b busy=%b, required 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    else n_pass++;
    send_word(word_of(pt, 2));
    send_word(word_of(pt, 3));
    n_checks++; if (bus.aes_text_in !== pt) $display("FAIL stray_done_block: text_in=%h, required %h", bus.aes_text_in, pt); else n_pass++;
    recv_block(fake_aes(model_key(), pt), 0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        int idx;
        logic [31:0] kv;
        idx = $urandom_range(0, 3);
        kv  = $urandom();
        key_write(2'(idx), kv);
        key_model[idx] = kv;
      end
      core_lat = $urandom_range(1, 6);
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_block(pt, 2);
      recv_block(fake_aes(model_key(), pt), 2);
    end
    load_fips_key();
  endtask

`ifdef AES_STREAM_TIMEOUT_EN
  task automatic test_timeout();
    logic [127:0] pt;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_hold = 1'b1;
    send_block(pt, 0);
    for (int c = 1; c <= int'(TMO); c++) begin
      tick();
      n_checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) $display("FAIL tmo_wait_c%0d: err=%b busy=%b, required 0/1", c, bus.err, bus.busy); else n_pass++;
    end
    tick();
    n_checks++; if (bus.err !== 1'b1) $display("FAIL tmo_err_set: err=%b, required 1", bus.err); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL tmo_back_to_fill: in_ready=%b busy=%b, required 1/0", bus.in_ready, bus.busy); else n_pass++;
    core_hold = 1'b0;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL tmo_err_clr: err=%b, required 0", bus.err); else n_pass++;
    // Done in the very cycle the count expires must win.
    core_lat = int'(TMO);
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(pt, 1);
    recv_block(fake_aes(model_key(), pt), 0);
    n_checks++; if (bus.err !== 1'b0) $display("FAIL tmo_done_priority: err=%b, required 0", bus.err); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    logic [127:0] pt;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_lat = 40;
    send_block(pt, 0);
    repeat (36) tick();
    n_checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) $display("FAIL notmo_still_wait: err=%b busy=%b, required 0/1", bus.err, bus.busy); else n_pass++;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    recv_block(fake_aes(model_key(), pt), 0);
    n_checks++; if (bus.err !== 1'b0) $display("FAIL notmo_err: err=%b, required 0", bus.err); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_wait();
    core_lat = 20;
    send_block(FIPS_PT, 0);
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.aes_ld !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL mid_rst_flags: in_ready=%b out_valid=%b aes_ld=%b busy=%b err=%b, required all 0", bus.in_ready, bus.out_valid, bus.aes_ld, bus.busy, bus.err);
    else n_pass++;
    n_checks++; if (bus.aes_key !== 128'd0 || bus.aes_text_in !== 128'd0 || bus.out_data !== 32'd0)
      $display("FAIL mid_rst_data: aes_key=%h text_in=%h out_data=%h, required all 0", bus.aes_key, bus.aes_text_in, bus.out_data);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus.aes_ld !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL mid_rst_hold_c%0d: aes_ld=%b in_ready=%b, required 0/0", c, bus.aes_ld, bus.in_ready); else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL mid_rst_release_pre: in_ready=%b, required 0", bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_release_edge: in_ready=%b, required 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) key_model[i] = '0;
    load_fips_key();
    core_lat = 3;
    send_block(FIPS_PT, 0);
    recv_block(FIPS_CT, 1);
  endtask

  initial begin
    bus.key_data = '0; bus.key_idx = '0; bus.key_we = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b0;
    test_reset();
    test_fips();
    test_backpressure();
    test_key_wait();
    test_stray_done();
    test_back_to_back();
`ifdef AES_STREAM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
